pc_fetch_control: RTL and testbench

Fetch-side controller that sits directly upstream of the instruction memory and owns its `pc`, `flashEn` and `flashInstruction` inputs. In FLASH mode it accepts a byte stream over a valid/ready handshake and writes it byte-by-byte into the instruction memory. In RUN mode it sequences the program counter: +4 per cycle, branch redirects and stalls. It stops in HALT when the pc leaves the loaded program image.

---
 rtl/pc_fetch_control.sv | 145 ++++++++++++++
 tb/tb_pc_fetch_control.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_control.sv
// Fetch-side controller: streams a program image into instruction memory,
// then sequences the pc with branch, stall and out-of-image halt handling.
module pc_fetch_control #(
    parameter int MEM_BYTES = 128,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flashReq,
    input  logic             byteValid,
    input  logic [7:0]       byteData,
    output logic             byteReady,
    input  logic             flashDone,
    input  logic             stall,
    input  logic             branchTaken,
    input  logic [63:0]      branchTarget,
    output logic [63:0]      pc,
    output logic             flashEn,
    output logic [7:0]       flashInstruction,
    output logic             pcValid,
    output logic             halted,
    output logic             fetchError,
    output logic [CNT_W-1:0] bytesLoaded
);

    typedef enum logic [1:0] {
        IDLE,
        FLASH,
        RUN,
        HALT
    } state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(MEM_BYTES);

    state_t           state, state_n;
    logic             pend, pend_n;
    logic [63:0]      pc_n;
    logic [7:0]       fi_n;
    logic             rdy_n, en_n, pv_n, h_n, err_n;
    logic [CNT_W-1:0] bl_n;

    logic             accept, misalign, beyond, exit_now;
    logic [CNT_W-1:0] bl_inc;
    logic [63:0]      nxt, bl_ext;

    assign accept   = byteValid & byteReady;
    assign bl_inc   = bytesLoaded + CNT_W'(1);
    assign bl_ext   = 64'(bytesLoaded);
    assign nxt      = branchTaken ? branchTarget : pc + 64'd4;
    assign misalign = branchTaken & (branchTarget[1:0] != 2'b00);
    assign beyond   = nxt >= bl_ext;
    // A byte arriving with flashDone is written first: exit waits one cycle
    assign exit_now = pend | (flashDone & ~accept);

    always_comb begin
        state_n = state;
        pend_n  = pend;
        pc_n    = pc;
        fi_n    = flashInstruction;
        rdy_n   = byteReady;
        en_n    = flashEn;
        pv_n    = pcValid;
        h_n     = halted;
        err_n   = fetchError;
        bl_n    = bytesLoaded;
        if (flashReq) begin
            state_n = FLASH;
            pend_n  = 1'b0;
            pc_n    = '0;
            bl_n    = '0;
            rdy_n   = 1'b1;
            en_n    = 1'b1;
            pv_n    = 1'b0;
            h_n     = 1'b0;
            err_n   = 1'b0;
        end else begin
            unique case (1'b1)
                (state == FLASH): begin
                    if (accept) begin
                        pc_n  = bl_ext;
                        fi_n  = byteData;
                        bl_n  = bl_inc;
                        rdy_n = bl_inc < FULL;
                    end
                    if (exit_now) begin
                        pend_n = 1'b0;
                        pc_n   = '0;
                        rdy_n  = 1'b0;
                        en_n   = 1'b0;
                        if (bytesLoaded == '0) begin
                            state_n = HALT;
                            h_n     = 1'b1;
                        end else begin
                            state_n = RUN;
                            pv_n    = 1'b1;
                        end
                    end else if (flashDone) begin
                        pend_n = 1'b1;
                        rdy_n  = 1'b0;
                    end
                end
                (state == RUN): begin
                    if (!stall) begin
                        if (misalign | beyond) begin
                            state_n = HALT;
                            pv_n    = 1'b0;
                            h_n     = 1'b1;
                            err_n   = misalign;
                        end else begin
                            pc_n = nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            pend             <= 1'b0;
            pc               <= '0;
            flashInstruction <= '0;
            byteReady        <= 1'b0;
            flashEn          <= 1'b0;
            pcValid          <= 1'b0;
            halted           <= 1'b0;
            fetchError       <= 1'b0;
            bytesLoaded      <= '0;
        end else begin
            state            <= state_n;
            pend             <= pend_n;
            pc               <= pc_n;
            flashInstruction <= fi_n;
            byteReady        <= rdy_n;
            flashEn          <= en_n;
            pcValid          <= pv_n;
            halted           <= h_n;
            fetchError       <= err_n;
            bytesLoaded      <= bl_n;
        end
    end

endmodule

// File: tb/tb_pc_fetch_control.sv
// Bench for pc_fetch_control: vector table, directed corner sequences and
// random traffic against a queue-based model of the loaded image.
module tb_pc_fetch_control;

    localparam int MEM_BYTES = 128;
    localparam int M_IDLE = 0, M_FLASH = 1, M_RUN = 2, M_HALT = 3;

    logic        clk = 1'b0;
    logic        reset, flashReq, byteValid, flashDone, stall, branchTaken;
    logic [7:0]  byteData;
    logic [63:0] branchTarget;
    logic        byteReady, flashEn, pcValid, halted, fetchError;
    logic [63:0] pc;
    logic [7:0]  flashInstruction;
    logic [7:0]  bytesLoaded;

    int n_cmp = 0;
    int n_bad = 0;

    pc_fetch_control #(.MEM_BYTES(MEM_BYTES), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .flashReq(flashReq),
        .byteValid(byteValid), .byteData(byteData),
        .byteReady(byteReady), .flashDone(flashDone),
        .stall(stall), .branchTaken(branchTaken),
        .branchTarget(branchTarget), .pc(pc), .flashEn(flashEn),
        .flashInstruction(flashInstruction), .pcValid(pcValid),
        .halted(halted), .fetchError(fetchError),
        .bytesLoaded(bytesLoaded)
    );

    always #5 clk = ~clk;

    // Instruction memory written from the DUT's write port
    logic [7:0] mem [256];
    logic       mem_clr = 1'b1;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'hEE;
        end else if (flashEn === 1'b1) begin
            mem[pc[7:0]] <= flashInstruction;
        end
    end

    // Reference model: image as a byte queue, mode tracked abstractly
    int          m_mode = M_IDLE;
    logic [7:0]  m_img[$];
    logic [63:0] m_pc = '0;
    logic [7:0]  m_fi = '0;
    bit          m_fe = 0;
    bit          m_pend = 0;

    function automatic bit m_ready();
        return m_mode == M_FLASH && !m_pend && m_img.size() < MEM_BYTES;
    endfunction

    task automatic model_step();
        bit acc;
        logic [63:0] tgt;
        if (reset) begin
            m_mode = M_IDLE; m_img.delete(); m_pc = '0;
            m_fi = '0; m_fe = 0; m_pend = 0;
        end else if (flashReq) begin
            m_mode = M_FLASH; m_img.delete(); m_pc = '0;
            m_fe = 0; m_pend = 0;
        end else if (m_mode == M_FLASH) begin
            acc = byteValid && m_ready();
            if (acc) begin
                m_img.push_back(byteData);
                m_pc = 64'(m_img.size() - 1);
                m_fi = byteData;
            end
            if (m_pend || (flashDone && !acc)) begin
                m_pend = 0;
                m_pc = '0;
                m_mode = (m_img.size() == 0) ? M_HALT : M_RUN;
            end else if (flashDone) begin
                m_pend = 1;
            end
        end else if (m_mode == M_RUN && !stall) begin
            tgt = branchTaken ? branchTarget : m_pc + 64'd4;
            if (branchTaken && tgt[1:0] != 2'b00) begin
                m_mode = M_HALT; m_fe = 1;
            end else if (tgt >= 64'(m_img.size())) begin
                m_mode = M_HALT;
            end else begin
                m_pc = tgt;
            end
        end
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("m.pc", pc, m_pc);
        chk("m.fi", 64'(flashInstruction), 64'(m_fi));
        chk("m.rdy", 64'(byteReady), 64'(m_ready()));
        chk("m.en", 64'(flashEn), 64'(m_mode == M_FLASH));
        chk("m.pv", 64'(pcValid), 64'(m_mode == M_RUN));
        chk("m.halt", 64'(halted), 64'(m_mode == M_HALT));
        chk("m.ferr", 64'(fetchError), 64'(m_fe));
        chk("m.bl", 64'(bytesLoaded), 64'(m_img.size()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        mem_clr = 1'b0;
        cmp_model();
    endtask

    task automatic idle_in();
        reset = 0; flashReq = 0; byteValid = 0; byteData = 0;
        flashDone = 0; stall = 0; branchTaken = 0; branchTarget = 0;
    endtask

    task automatic load(int n, logic [7:0] base);
        flashReq = 1; tick(); flashReq = 0;
        for (int i = 0; i < n; i++) begin
            byteValid = 1; byteData = 8'(base + 8'(i)); tick();
        end
        byteValid = 0; flashDone = 1; tick(); flashDone = 0;
    endtask

    typedef struct {
        logic fr, bv; logic [7:0] bd; logic fd;
        logic [63:0] epc; logic [7:0] efi;
        logic erdy, een, epv, eh; logic [7:0] ebl;
    } vec_t;

    vec_t       vt[13];
    logic [7:0] pb[8] = '{8'h83, 8'h30, 8'h00, 8'h00,
                          8'h03, 8'h31, 8'h80, 8'h00};

    initial begin
        idle_in();
        reset = 1; tick();
        chk("rst.pc", pc, 64'd0);
        chk("rst.rdy", 64'(byteReady), 64'd0);
        chk("rst.halt", 64'(halted), 64'd0);
        reset = 0;

        // Basic 8-byte program and run-off-end halt
        vt[0] = '{1, 0, 8'h00, 0, 64'd0, 8'h00, 1, 1, 0, 0, 8'd0};
        for (int i = 0; i < 8; i++)
            vt[i+1] = '{0, 1, pb[i], 0, 64'(i), pb[i],
                        1, 1, 0, 0, 8'(i + 1)};
        vt[9]  = '{0, 0, 8'h00, 1, 64'd0, 8'h00, 0, 0, 1, 0, 8'd8};
        vt[10] = '{0, 0, 8'h00, 0, 64'd4, 8'h00, 0, 0, 1, 0, 8'd8};
        vt[11] = '{0, 0, 8'h00, 0, 64'd4, 8'h00, 0, 0, 0, 1, 8'd8};
        vt[12] = vt[11];
        for (int i = 0; i < 13; i++) begin
            flashReq = vt[i].fr; byteValid = vt[i].bv;
            byteData = vt[i].bd; flashDone = vt[i].fd;
            tick();
            chk($sformatf("v%0d.pc", i), pc, vt[i].epc);
            chk($sformatf("v%0d.fi", i), 64'(flashInstruction),
                64'(vt[i].efi));
            chk($sformatf("v%0d.rdy", i), 64'(byteReady), 64'(vt[i].erdy));
            chk($sformatf("v%0d.en", i), 64'(flashEn), 64'(vt[i].een));
            chk($sformatf("v%0d.pv", i), 64'(pcValid), 64'(vt[i].epv));
            chk($sformatf("v%0d.h", i), 64'(halted), 64'(vt[i].eh));
            chk($sformatf("v%0d.bl", i), 64'(bytesLoaded), 64'(vt[i].ebl));
        end
        idle_in();
        for (int i = 0; i < 8; i++)
            chk($sformatf("mem%0d", i), 64'(mem[i]), 64'(pb[i]));

        // 16 bytes with byteValid on alternate cycles
        flashReq = 1; tick(); flashReq = 0;
        for (int i = 0; i < 32; i++) begin
            byteValid = (i % 2 == 0); byteData = 8'(i); tick();
            chk("gap.pc", pc, 64'(i / 2));
        end
        byteValid = 0;
        chk("gap.bl", 64'(bytesLoaded), 64'd16);

        // Full memory, 129th byte refused
        flashReq = 1; tick(); flashReq = 0;
        for (int i = 0; i < 128; i++) begin
            byteValid = 1; byteData = 8'(i) ^ 8'h5A; tick();
        end
        chk("full.rdy", 64'(byteReady), 64'd0);
        chk("full.bl", 64'(bytesLoaded), 64'd128);
        byteData = 8'hC3; tick(); tick();
        chk("full.pc", pc, 64'd127);
        chk("full.fi", 64'(flashInstruction), 64'(8'd127 ^ 8'h5A));
        chk("full.bl2", 64'(bytesLoaded), 64'd128);
        byteValid = 0; flashDone = 1; tick(); flashDone = 0;
        chk("full.m127", 64'(mem[127]), 64'(8'd127 ^ 8'h5A));
        chk("full.m128", 64'(mem[128]), 64'hEE);
        chk("full.pv", 64'(pcValid), 64'd1);

        // Branches: in-range, past end, misaligned
        load(24, 8'h10);
        tick(); tick();
        chk("br.pc8", pc, 64'd8);
        branchTaken = 1; branchTarget = 64'd20; tick();
        chk("br.pc20", pc, 64'd20);
        branchTarget = 64'd24; tick();
        chk("br.end.h", 64'(halted), 64'd1);
        chk("br.end.pc", pc, 64'd20);
        chk("br.end.fe", 64'(fetchError), 64'd0);
        branchTaken = 0;
        load(24, 8'h20);
        chk("br.clr.h", 64'(halted), 64'd0);
        branchTaken = 1; branchTarget = 64'd6; tick();
        chk("br.mis.h", 64'(halted), 64'd1);
        chk("br.mis.fe", 64'(fetchError), 64'd1);
        chk("br.mis.pc", pc, 64'd0);
        branchTaken = 0;

        // Stall holds the pc while a branch is pending
        load(24, 8'h30);
        tick();
        stall = 1; branchTaken = 1; branchTarget = 64'd12;
        tick(); chk("st.pc1", pc, 64'd4);
        tick(); chk("st.pc2", pc, 64'd4);
        stall = 0; tick(); chk("st.pc12", pc, 64'd12);
        branchTaken = 0;

        // flashDone together with the last byte
        flashReq = 1; tick(); flashReq = 0;
        for (int i = 0; i < 3; i++) begin
            byteValid = 1; byteData = 8'(i); tick();
        end
        byteData = 8'hA7; flashDone = 1; tick();
        chk("fd.pc", pc, 64'd3);
        chk("fd.bl", 64'(bytesLoaded), 64'd4);
        byteValid = 0; flashDone = 0; tick();
        chk("fd.pv", 64'(pcValid), 64'd1);
        chk("fd.m3", 64'(mem[3]), 64'hA7);

        // Reset in the middle of a load
        flashReq = 1; tick(); flashReq = 0;
        for (int i = 0; i < 3; i++) begin
            byteValid = 1; byteData = 8'h40 + 8'(i); tick();
        end
        byteValid = 0; reset = 1; tick();
        chk("rm.pc", pc, 64'd0);
        chk("rm.fi", 64'(flashInstruction), 64'd0);
        chk("rm.en", 64'(flashEn), 64'd0);
        chk("rm.bl", 64'(bytesLoaded), 64'd0);
        reset = 0; flashReq = 1; tick(); flashReq = 0;
        chk("rm.re.rdy", 64'(byteReady), 64'd1);

        // Empty load halts
        flashDone = 1; tick(); flashDone = 0;
        chk("empty.h", 64'(halted), 64'd1);
        chk("empty.pv", 64'(pcValid), 64'd0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            flashReq = ($urandom_range(0, 79) == 0);
            byteValid = ($urandom_range(0, 9) < 7);
            byteData = 8'($urandom);
            flashDone = ($urandom_range(0, 29) == 0);
            stall = ($urandom_range(0, 4) == 0);
            branchTaken = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 9))
                0: branchTarget = 64'($urandom_range(0, 63));
                1: branchTarget = 64'hFFFF_FFFF_FFFF_FFF0;
                default: branchTarget = 64'($urandom_range(0, 40) * 4);
            endcase
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
